// File: rtl/risc16_pkg.sv
// Shared RISC-16 core types: machine word, fetch FSM states and the
// instruction-buffer entry that pairs a fetched word with its PC.
package risc16_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [0:0] {
      FETCH_RUN    = 1'b0,
      FETCH_HALTED = 1'b1
   } fetch_state_e;

   typedef struct packed {
      word_t instr;
      word_t pc;
   } fetch_entry_t;

   localparam word_t RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect/halt
// and the decode valid/ready handshake. master = fetch unit, slave = its environment.
interface fetch_unit_if;
   import risc16_pkg::*;

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never waits for ready, and the payload is held while valid && !ready.
   // Memory responses are in order and have no backpressure.
   logic         anOutMemReqValid;
   logic         aMemReqReady;
   word_t        anOutMemAddr;
   logic         aMemRespValid;
   word_t        aMemRespData;
   logic         aRedirectValid;
   word_t        aRedirectTarget;
   logic         aHalt;
   logic         anOutValid;
   logic         aReady;
   word_t        anOutInstruction;
   word_t        anOutPC;
   logic         anOutHalted;
   fetch_state_e anOutDbgState;

   modport master (
      output anOutMemReqValid, anOutMemAddr, anOutValid, anOutInstruction,
             anOutPC, anOutHalted, anOutDbgState,
      input  aMemReqReady, aMemRespValid, aMemRespData, aRedirectValid,
             aRedirectTarget, aHalt, aReady
   );

   modport slave (
      input  anOutMemReqValid, anOutMemAddr, anOutValid, anOutInstruction,
             anOutPC, anOutHalted, anOutDbgState,
      output aMemReqReady, aMemRespValid, aMemRespData, aRedirectValid,
             aRedirectTarget, aHalt, aReady
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular queue of fetched instructions tagged with their PC.
// Flush wins over push/pop; a push into a full queue is legal only with a pop.
module fetch_fifo
   import risc16_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  fetch_entry_t     push_data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output fetch_entry_t     head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && !flush_i && full_o && !pop_i));

endmodule

// File: rtl/fetch_unit.sv
// RISC-16 instruction fetch: owns the PC, issues credit-limited in-order
// memory reads, buffers responses for decode, and handles redirects and halt.
module fetch_unit
   import risc16_pkg::*;
#(
   parameter int    DEPTH    = 2,
   parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
   input logic          aClock,
   input logic          aReset,
   fetch_unit_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_state_e     state_q;
   logic             halted_q;
   word_t            fetch_pc_q, fetch_pc_d;
   word_t            resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] discard_q, discard_d;

   fetch_entry_t     fifo_head;
   fetch_entry_t     fifo_push_data;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;

   logic             run;
   logic             halt_now;
   logic             redirect_now;
   logic             resp_ack;
   logic [CNT_W:0]   in_use;
   logic             credit_ok;
   logic             req_valid;
   logic             req_fire;
   logic             push;
   logic             pop;
   logic             flush;

   assign run          = (state_q == FETCH_RUN);
   assign halt_now     = run && bus.aHalt;
   assign redirect_now = run && !bus.aHalt && bus.aRedirectValid;
   // A response with nothing outstanding is ignored so the counter cannot underflow.
   assign resp_ack     = bus.aMemRespValid && (outstanding_q != '0);

   // Buffered plus in-flight words may never exceed the buffer size.
   assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
   assign credit_ok = !fifo_full && (in_use < (CNT_W + 1)'(DEPTH));
   assign req_valid = !aReset && run && credit_ok && !bus.aRedirectValid && !bus.aHalt;
   assign req_fire  = req_valid && bus.aMemReqReady;

   assign push  = run && !bus.aHalt && !bus.aRedirectValid && resp_ack && (discard_q == '0);
   assign pop   = bus.anOutValid && bus.aReady;
   assign flush = halt_now || redirect_now;

   assign fifo_push_data = '{instr: bus.aMemRespData, pc: resp_pc_q};

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_ack);
      discard_d     = discard_q;
      if (halt_now) begin
         discard_d = '0;
      end else if (redirect_now) begin
         fetch_pc_d = bus.aRedirectTarget;
         resp_pc_d  = bus.aRedirectTarget;
         // Everything still in flight belongs to the old stream; this cycle's
         // response is already being dropped, so it is not counted again.
         discard_d  = outstanding_q - CNT_W'(resp_ack);
      end else if (run) begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 1'b1;
         if (push)     resp_pc_d  = resp_pc_q + 1'b1;
         if (resp_ack && (discard_q != '0)) discard_d = discard_q - 1'b1;
      end
   end

   always_ff @(posedge aClock or posedge aReset) begin
      if (aReset) begin
         state_q       <= FETCH_RUN;
         halted_q      <= 1'b0;
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         case (state_q)
            FETCH_RUN: begin
               if (bus.aHalt) begin
                  state_q  <= FETCH_HALTED;
                  halted_q <= 1'b1;
               end
            end
            FETCH_HALTED: begin
               state_q  <= FETCH_HALTED;
               halted_q <= 1'b1;
            end
            default: begin
               state_q  <= FETCH_RUN;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (aClock),
      .rst_i       (aReset),
      .push_i      (push),
      .push_data_i (fifo_push_data),
      .pop_i       (pop),
      .flush_i     (flush),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign bus.anOutMemReqValid = req_valid;
   assign bus.anOutMemAddr     = fetch_pc_q;
   assign bus.anOutValid       = run && !fifo_empty;
   assign bus.anOutInstruction = fifo_head.instr;
   assign bus.anOutPC          = fifo_head.pc;
   assign bus.anOutHalted      = halted_q;
   assign bus.anOutDbgState    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction-memory model with programmable latency and
// a scoreboard of expected {pc, instr} beats built from the requests issued.
module tb_fetch_unit;
   import risc16_pkg::*;

   localparam int    DEPTH    = 2;
   localparam word_t RESET_PC = 16'h0000;

   typedef struct {
      int    due;
      word_t data;
   } mem_rsp_t;

   logic clk = 1'b0;
   logic rst;

   fetch_unit_if bus();

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .aClock (clk),
      .aReset (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc;
   int          mem_lat;
   int          req_count;
   int          first_req_cyc;
   int          first_valid_cyc;
   mem_rsp_t    mem_q[$];
   logic [31:0] exp_q[$];
   word_t       post_pcs[$];
   word_t       exp_fetch_pc;
   bit          halted_exp;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] post_pc(input int i);
      if (post_pcs.size() > i) return {16'h0, post_pcs[i]};
      return 32'hFFFF_FFFF;
   endfunction

   // One clock cycle: entered just after a falling edge with this cycle's inputs set.
   task automatic tick();
      mem_rsp_t    r;
      logic [31:0] e;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
         r = mem_q.pop_front();
         bus.aMemRespValid = 1'b1;
         bus.aMemRespData  = r.data;
      end else begin
         bus.aMemRespValid = 1'b0;
         bus.aMemRespData  = 16'($urandom);
      end
      #1;
      if (!rst && halted_exp) begin
         check_eq("halt_no_valid", 32'(bus.anOutValid), 32'd0);
         check_eq("halt_no_req", 32'(bus.anOutMemReqValid), 32'd0);
         check_eq("halted_flag", 32'(bus.anOutHalted), 32'd1);
         check_eq("dbg_state", 32'(bus.anOutDbgState), 32'(FETCH_HALTED));
      end
      if (bus.anOutMemReqValid && bus.aMemReqReady) begin
         check_eq("req_addr", 32'(bus.anOutMemAddr), 32'(exp_fetch_pc));
         exp_q.push_back({exp_fetch_pc, exp_fetch_pc ^ 16'hA5A5});
         mem_q.push_back('{cyc + mem_lat, bus.anOutMemAddr ^ 16'hA5A5});
         exp_fetch_pc++;
         req_count++;
         if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (bus.anOutValid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.anOutValid && bus.aReady) begin
         check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("beat_pc", 32'(bus.anOutPC), 32'(e[31:16]));
            check_eq("beat_instr", 32'(bus.anOutInstruction), 32'(e[15:0]));
         end
         post_pcs.push_back(bus.anOutPC);
      end
      if (!rst && !halted_exp && (bus.aHalt || bus.aRedirectValid)) begin
         check_eq("no_req_on_redirect", 32'(bus.anOutMemReqValid), 32'd0);
         exp_q.delete();
         if (bus.aHalt) halted_exp = 1'b1;
         else           exp_fetch_pc = bus.aRedirectTarget;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst                 = 1'b1;
      bus.aReady          = 1'b0;
      bus.aMemReqReady    = 1'b1;
      bus.aRedirectValid  = 1'b0;
      bus.aRedirectTarget = 16'h0;
      bus.aHalt           = 1'b0;
      mem_q.delete();
      exp_q.delete();
      post_pcs.delete();
      exp_fetch_pc    = RESET_PC;
      halted_exp      = 1'b0;
      req_count       = 0;
      first_req_cyc   = -1;
      first_valid_cyc = -1;
      tick();
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic redirect_cycle(input word_t target);
      bus.aReady          = 1'b0;
      bus.aRedirectValid  = 1'b1;
      bus.aRedirectTarget = target;
      tick();
      bus.aRedirectValid  = 1'b0;
      bus.aReady          = 1'b1;
      post_pcs.delete();
   endtask

   initial begin
      rst                = 1'b1;
      bus.aReady         = 1'b0;
      bus.aMemReqReady   = 1'b1;
      bus.aMemRespValid  = 1'b0;
      bus.aMemRespData   = 16'h0;
      bus.aRedirectValid = 1'b0;
      bus.aRedirectTarget= 16'h0;
      bus.aHalt          = 1'b0;
      cyc                = 0;
      mem_lat            = 1;
      @(negedge clk);
      check_eq("rst_req_valid", 32'(bus.anOutMemReqValid), 32'd0);
      check_eq("rst_mem_addr", 32'(bus.anOutMemAddr), 32'(RESET_PC));
      check_eq("rst_out_valid", 32'(bus.anOutValid), 32'd0);
      check_eq("rst_instr", 32'(bus.anOutInstruction), 32'd0);
      check_eq("rst_pc", 32'(bus.anOutPC), 32'd0);
      check_eq("rst_halted", 32'(bus.anOutHalted), 32'd0);

      // Free run with a 1-cycle memory, then random decode backpressure.
      do_reset();
      mem_lat    = 1;
      bus.aReady = 1'b1;
      repeat (30) tick();
      check_eq("first_beat_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);
      check_eq("free_run_beats", 32'(post_pcs.size() >= 10), 32'd1);
      check_eq("free_run_pc0", post_pc(0), 32'h0000);
      check_eq("free_run_pc1", post_pc(1), 32'h0001);
      repeat (60) begin
         bus.aReady = 1'($urandom_range(0, 1));
         tick();
      end

      // Decode stalled: exactly DEPTH requests, head held, refill only after a pop.
      do_reset();
      mem_lat    = 1;
      bus.aReady = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i >= 2) begin
            check_eq("stall_valid", 32'(bus.anOutValid), 32'd1);
            check_eq("stall_pc", 32'(bus.anOutPC), 32'(RESET_PC));
            check_eq("stall_instr", 32'(bus.anOutInstruction), 32'(RESET_PC ^ 16'hA5A5));
         end
      end
      check_eq("stall_req_count", 32'(req_count), 32'(DEPTH));
      check_eq("stall_no_req", 32'(bus.anOutMemReqValid), 32'd0);
      bus.aReady = 1'b1;
      tick();
      check_eq("req_after_pop", 32'(bus.anOutMemReqValid), 32'd1);
      repeat (10) tick();

      // Redirect with two requests outstanding and no response that cycle.
      do_reset();
      mem_lat    = 3;
      bus.aReady = 1'b1;
      tick();
      tick();
      redirect_cycle(16'h0040);
      repeat (20) tick();
      check_eq("redir2_first_pc", post_pc(0), 32'h0040);
      check_eq("redir2_second_pc", post_pc(1), 32'h0041);

      // Redirect while a stale response arrives and one more is in flight.
      do_reset();
      mem_lat    = 2;
      bus.aReady = 1'b1;
      tick();
      tick();
      redirect_cycle(16'h0100);
      repeat (20) tick();
      check_eq("redir1_first_pc", post_pc(0), 32'h0100);
      check_eq("redir1_second_pc", post_pc(1), 32'h0101);

      // PC wrap from FFFF to 0000.
      do_reset();
      mem_lat = 1;
      redirect_cycle(16'hFFFF);
      repeat (15) tick();
      check_eq("wrap_pc0", post_pc(0), 32'hFFFF);
      check_eq("wrap_pc1", post_pc(1), 32'h0000);
      check_eq("wrap_pc2", post_pc(2), 32'h0001);

      // Halt together with a redirect, one request in flight; reset releases it.
      do_reset();
      mem_lat    = 2;
      bus.aReady = 1'b1;
      tick();
      bus.aReady          = 1'b0;
      bus.aHalt           = 1'b1;
      bus.aRedirectValid  = 1'b1;
      bus.aRedirectTarget = 16'h0200;
      tick();
      bus.aHalt          = 1'b0;
      bus.aRedirectValid = 1'b0;
      bus.aReady         = 1'b1;
      repeat (6) tick();
      check_eq("halt_req_count", 32'(req_count), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("halt_rst_halted", 32'(bus.anOutHalted), 32'd0);
      check_eq("halt_rst_state", 32'(bus.anOutDbgState), 32'(FETCH_RUN));
      check_eq("halt_rst_addr", 32'(bus.anOutMemAddr), 32'(RESET_PC));
      do_reset();
      mem_lat    = 1;
      bus.aReady = 1'b1;
      repeat (12) tick();
      check_eq("after_halt_pc0", post_pc(0), 32'(RESET_PC));
      check_eq("after_halt_pc1", post_pc(1), 32'(RESET_PC + 16'h1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
